// File: rtl/ecc_pkg.sv
// Shared SECDED helpers for the extended Hamming encoder/decoder pair.
// Codeword layout: data bits sit at the non-power-of-2 positions 1..n, parity bit
// p[i] sits at position 2^(i-1), and the overall parity p0 is kept outside cw[n:1].
package ecc_pkg;

  typedef enum logic [1:0] {ECC_OK, ECC_SB, ECC_DB} ecc_stat_t;

  // Smallest m with 2^m >= m + k + 1.
  function automatic int unsigned calculate_m(input int unsigned k);
    int unsigned m;
    m = 1;
    while ((32'd1 << m) < (m + k + 1)) m++;
    return m;
  endfunction

  function automatic bit is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

  // Codeword position of information bit b: the b-th non-power-of-2 position,
  // counting upwards from position 1.
  function automatic int unsigned data_pos(input int unsigned b);
    int unsigned pos;
    int unsigned cnt;
    bit          found;
    pos   = 0;
    cnt   = 0;
    found = 1'b0;
    for (int unsigned j = 1; j < 4096; j++) begin
      if (!found && !is_pow2(j)) begin
        if (cnt == b) begin
          pos   = j;
          found = 1'b1;
        end
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// Combinational syndrome / overall-parity generator for the extended Hamming code.
// Ports:
//   cw_i  codeword bits at positions N..1 (stored parity bits included)
//   p0_i  overall parity bit
//   s_o   syndrome; s_o[i] covers every position whose bit i is set
//   pe_o  XOR of all N+1 received bits (1 = odd number of flips)
module ecc_syndrome #(
  parameter int unsigned M = 4,
  parameter int unsigned N = 12
) (
  input  logic [N:1]   cw_i,
  input  logic         p0_i,
  output logic [M-1:0] s_o,
  output logic         pe_o
);

  always_comb begin
    s_o = '0;
    for (int unsigned i = 0; i < M; i++) begin
      for (int unsigned j = 1; j <= N; j++) begin
        if (((j >> i) & 32'd1) == 32'd1) s_o[i] = s_o[i] ^ cw_i[j];
      end
    end
  end

  assign pe_o = ^{cw_i, p0_i};

endmodule

// File: rtl/ecc_dec_stream.sv
// Two-stage pipelined SECDED decoder on a valid/ready stream, with saturating
// single/double error counters. Stage 1 registers the codeword, syndrome and overall
// parity; stage 2 corrects, extracts the data and holds the output register.
// The whole pipeline stalls globally when the output is held.
//
// Optional feature macro: ECC_DEC_STREAM_CNT_EN
//   defined   : sb_cnt_o/db_cnt_o count corrected/uncorrectable words, clr_cnt_i clears
//   undefined : no counter flops, counts tied to 0, clr_cnt_i ignored
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   valid_i/ready_o/d_i  input codeword stream (d_i is n+1 bits)
//   valid_o/ready_i/q_o  output data stream (K bits)
//   syndrome_o          syndrome of the word on q_o
//   sb_err_o            single error corrected (includes p0-only error)
//   db_err_o            uncorrectable error; q_o carries raw data
//   clr_cnt_i           synchronous clear of both counters
//   sb_cnt_o, db_cnt_o  saturating error counts
module ecc_dec_stream import ecc_pkg::*; #(
  parameter int unsigned K      = 8,
  parameter bit          P0_LSB = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [calculate_m(K)+K:0] d_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [K-1:0]              q_o,
  output logic [calculate_m(K)-1:0] syndrome_o,
  output logic                      sb_err_o,
  output logic                      db_err_o,
  input  logic                      clr_cnt_i,
  output logic [CNT_W-1:0]          sb_cnt_o,
  output logic [CNT_W-1:0]          db_cnt_o
);

  localparam int unsigned M = calculate_m(K);
  localparam int unsigned N = M + K;

  // Handshake: global stall.
  logic adv1, adv2, s2_load;
  logic s1_valid_q, valid_q;

  assign adv2    = ~valid_q | ready_i;
  assign adv1    = ~s1_valid_q | adv2;
  assign ready_o = adv1;
  assign s2_load = s1_valid_q & adv2;

  // Stage 1: split, syndrome, register.
  logic [N:1]   cw_in;
  logic         p0_in;
  logic [M-1:0] s_in;
  logic         pe_in;

  always_comb begin
    if (P0_LSB) begin
      cw_in = d_i[N:1];
      p0_in = d_i[0];
    end else begin
      cw_in = d_i[N-1:0];
      p0_in = d_i[N];
    end
  end

  ecc_syndrome #(
    .M (M),
    .N (N)
  ) u_syndrome (
    .cw_i (cw_in),
    .p0_i (p0_in),
    .s_o  (s_in),
    .pe_o (pe_in)
  );

  logic [N:1]   s1_cw_q;
  logic [M-1:0] s1_s_q;
  logic         s1_pe_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_s_q     <= '0;
      s1_pe_q    <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= valid_i;
      if (valid_i) begin
        s1_cw_q <= cw_in;
        s1_s_q  <= s_in;
        s1_pe_q <= pe_in;
      end
    end
  end

  // Stage 2: classify, correct, extract.
  ecc_stat_t    stat_d;
  logic [N:1]   cw_fix;
  logic [K-1:0] q_ext;

  always_comb begin
    stat_d = ECC_OK;
    cw_fix = s1_cw_q;
    if (s1_s_q == '0) begin
      stat_d = s1_pe_q ? ECC_SB : ECC_OK;
    end else if (s1_pe_q && (int'(s1_s_q) <= int'(N))) begin
      stat_d = ECC_SB;
      for (int unsigned j = 1; j <= N; j++) begin
        if (s1_s_q == M'(j)) cw_fix[j] = ~cw_fix[j];
      end
    end else begin
      // Even flip count with nonzero syndrome, or a syndrome pointing past the word.
      stat_d = ECC_DB;
    end
  end

  for (genvar b = 0; b < K; b++) begin : g_extract
    localparam int unsigned Pos = data_pos(b);
    assign q_ext[b] = cw_fix[Pos];
  end

  logic [K-1:0] q_q;
  logic [M-1:0] syn_q;
  logic         sb_q, db_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      q_q     <= '0;
      syn_q   <= '0;
      sb_q    <= 1'b0;
      db_q    <= 1'b0;
    end else if (adv2) begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        q_q   <= q_ext;
        syn_q <= s1_s_q;
        sb_q  <= (stat_d == ECC_SB);
        db_q  <= (stat_d == ECC_DB);
      end
    end
  end

  assign valid_o    = valid_q;
  assign q_o        = q_q;
  assign syndrome_o = syn_q;
  assign sb_err_o   = sb_q;
  assign db_err_o   = db_q;

`ifdef ECC_DEC_STREAM_CNT_EN
  logic [CNT_W-1:0] sb_cnt_q, db_cnt_q;

  // Count on the S2 load edge only, so a stalled word is counted once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sb_cnt_q <= '0;
      db_cnt_q <= '0;
    end else if (clr_cnt_i) begin
      sb_cnt_q <= '0;
      db_cnt_q <= '0;
    end else if (s2_load) begin
      if ((stat_d == ECC_SB) && (sb_cnt_q != '1)) sb_cnt_q <= sb_cnt_q + CNT_W'(1);
      if ((stat_d == ECC_DB) && (db_cnt_q != '1)) db_cnt_q <= db_cnt_q + CNT_W'(1);
    end
  end

  assign sb_cnt_o = sb_cnt_q;
  assign db_cnt_o = db_cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = clr_cnt_i ^ s2_load;
  assign sb_cnt_o   = '0;
  assign db_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_ecc_dec_stream.sv
// Directed bench for ecc_dec_stream with K=8, P0_LSB=1 (m=4, n=12).
// A second instance with CNT_W=2 exercises counter saturation and clear priority.
module tb_ecc_dec_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_i, clr;
  logic [12:0] d;
  logic        ready_o, valid_o, sb_err, db_err;
  logic [7:0]  q;
  logic [3:0]  syn;
  logic [15:0] sb_cnt, db_cnt;

  logic        s_valid_i, s_clr;
  logic [12:0] s_d;
  logic        s_ready_o, s_valid_o, s_sb_err, s_db_err;
  logic [7:0]  s_q;
  logic [3:0]  s_syn;
  logic [1:0]  s_sb_cnt, s_db_cnt;

  int errors = 0;
  int checks = 0;
  int unsigned exp_sb = 0;
  int unsigned exp_db = 0;

  always #5 clk = ~clk;

  ecc_dec_stream #(.K(8), .P0_LSB(1'b1), .CNT_W(16)) u_dut (
    .clk_i (clk), .rst_i (rst), .valid_i (valid_i), .ready_o (ready_o), .d_i (d),
    .valid_o (valid_o), .ready_i (ready_i), .q_o (q), .syndrome_o (syn),
    .sb_err_o (sb_err), .db_err_o (db_err), .clr_cnt_i (clr),
    .sb_cnt_o (sb_cnt), .db_cnt_o (db_cnt)
  );

  ecc_dec_stream #(.K(8), .P0_LSB(1'b1), .CNT_W(2)) u_sat (
    .clk_i (clk), .rst_i (rst), .valid_i (s_valid_i), .ready_o (s_ready_o), .d_i (s_d),
    .valid_o (s_valid_o), .ready_i (1'b1), .q_o (s_q), .syndrome_o (s_syn),
    .sb_err_o (s_sb_err), .db_err_o (s_db_err), .clr_cnt_i (s_clr),
    .sb_cnt_o (s_sb_cnt), .db_cnt_o (s_db_cnt)
  );

  // Counter outputs are only live when the counter feature is compiled in.
  function automatic logic [15:0] cnt_exp(input int unsigned v);
`ifdef ECC_DEC_STREAM_CNT_EN
    return 16'(v);
`else
    return 16'(v * 0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word, then wait for it to reach the output register.
  task automatic send_one(input logic [12:0] w);
    valid_i = 1'b1; d = w; ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; clr = 1'b0; d = '0;
    s_valid_i = 1'b0; s_clr = 1'b0; s_d = '0;
    tick(); tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid_o); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", q); end
    checks++; if ({sb_err, db_err, syn} !== 6'd0) begin errors++; $display("FAIL reset_flags got %b want 0", {sb_err, db_err, syn}); end
    checks++; if ({sb_cnt, db_cnt} !== 32'd0) begin errors++; $display("FAIL reset_cnt got %h want 0", {sb_cnt, db_cnt}); end
    rst = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", ready_o); end
    tick();
  endtask

  task automatic test_clean();
    valid_i = 1'b1; d = 13'h144E; ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL clean_latency1 valid got %0b want 0", valid_o); end
    tick();
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL clean_latency2 valid got %0b want 1", valid_o); end
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL clean_q got %h want a5", q); end
    checks++; if ({syn, sb_err, db_err} !== 6'd0) begin errors++; $display("FAIL clean_flags got %b want 0", {syn, sb_err, db_err}); end
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL clean_nodup valid got %0b want 0", valid_o); end
    checks++; if (sb_cnt !== cnt_exp(exp_sb) || db_cnt !== cnt_exp(exp_db)) begin errors++; $display("FAIL clean_cnt got %0d/%0d want %0d/%0d", sb_cnt, db_cnt, cnt_exp(exp_sb), cnt_exp(exp_db)); end
  endtask

  task automatic test_single();
    send_one(13'h140E); exp_sb++;
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL single_q got %h want a5", q); end
    checks++; if (syn !== 4'd6) begin errors++; $display("FAIL single_syn got %0d want 6", syn); end
    checks++; if ({sb_err, db_err} !== 2'b10) begin errors++; $display("FAIL single_flags got %b want 10", {sb_err, db_err}); end
    checks++; if (sb_cnt !== cnt_exp(exp_sb)) begin errors++; $display("FAIL single_cnt got %0d want %0d", sb_cnt, cnt_exp(exp_sb)); end
  endtask

  task automatic test_p0_and_double();
    send_one(13'h144F); exp_sb++;
    checks++; if (q !== 8'hA5 || syn !== 4'd0) begin errors++; $display("FAIL p0_data got q=%h syn=%0d want a5/0", q, syn); end
    checks++; if ({sb_err, db_err} !== 2'b10) begin errors++; $display("FAIL p0_flags got %b want 10", {sb_err, db_err}); end
    send_one(13'h1466); exp_db++;
    checks++; if ({sb_err, db_err} !== 2'b01) begin errors++; $display("FAIL double_flags got %b want 01", {sb_err, db_err}); end
    checks++; if (syn !== 4'd6 || q !== 8'hA6) begin errors++; $display("FAIL double_raw got q=%h syn=%0d want a6/6", q, syn); end
    checks++; if (db_cnt !== cnt_exp(exp_db) || sb_cnt !== cnt_exp(exp_sb)) begin errors++; $display("FAIL double_cnt got %0d/%0d want %0d/%0d", sb_cnt, db_cnt, cnt_exp(exp_sb), cnt_exp(exp_db)); end
  endtask

  task automatic test_out_of_range();
    send_one(13'h155C); exp_db++;
    checks++; if ({sb_err, db_err} !== 2'b01) begin errors++; $display("FAIL oor_flags got %b want 01", {sb_err, db_err}); end
    checks++; if (syn !== 4'd13 || q !== 8'hA5) begin errors++; $display("FAIL oor_raw got q=%h syn=%0d want a5/13", q, syn); end
    checks++; if (db_cnt !== cnt_exp(exp_db)) begin errors++; $display("FAIL oor_cnt got %0d want %0d", db_cnt, cnt_exp(exp_db)); end
  endtask

  logic [12:0] bp_d   [4] = '{13'h144E, 13'h0020, 13'h1EEE, 13'h1466};
  logic [7:0]  bp_q   [4] = '{8'hA5, 8'h00, 8'hFF, 8'hA6};
  logic [3:0]  bp_syn [4] = '{4'd0, 4'd5, 4'd0, 4'd6};
  logic [1:0]  bp_fl  [4] = '{2'b00, 2'b10, 2'b00, 2'b01};

  task automatic test_back_to_back();
    int  in_idx = 0;
    int  out_idx = 0;
    bit  stall_seen = 1'b0;
    bit  acc;
    tick();
    for (int c = 0; c < 30 && out_idx < 4; c++) begin
      valid_i = (in_idx < 4);
      d       = bp_d[in_idx < 4 ? in_idx : 0];
      ready_i = !(c >= 1 && c <= 3);
      #1;
      if (!ready_o && !stall_seen) begin
        stall_seen = 1'b1;
        checks++; if (in_idx != 2) begin errors++; $display("FAIL bp_ready_drop accepted=%0d want 2", in_idx); end
      end
      if (valid_o && ready_i) begin
        checks++;
        if (q !== bp_q[out_idx] || syn !== bp_syn[out_idx] || {sb_err, db_err} !== bp_fl[out_idx]) begin
          errors++;
          $display("FAIL bp_word%0d got q=%h syn=%0d fl=%b want q=%h syn=%0d fl=%b", out_idx, q, syn,
                   {sb_err, db_err}, bp_q[out_idx], bp_syn[out_idx], bp_fl[out_idx]);
        end
        out_idx++;
      end else if (valid_o) begin
        checks++; if (q !== bp_q[out_idx] || syn !== bp_syn[out_idx]) begin errors++; $display("FAIL bp_hold got q=%h want %h", q, bp_q[out_idx]); end
      end
      acc = valid_i && ready_o;
      @(posedge clk); #1;
      if (acc) in_idx++;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    exp_sb++; exp_db++;
    checks++; if (out_idx != 4) begin errors++; $display("FAIL bp_count got %0d words want 4", out_idx); end
    checks++; if (!stall_seen) begin errors++; $display("FAIL bp_stall ready_o never dropped want drop"); end
    tick(); tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_nodup valid got %0b want 0", valid_o); end
    checks++; if (sb_cnt !== cnt_exp(exp_sb) || db_cnt !== cnt_exp(exp_db)) begin errors++; $display("FAIL bp_cnt got %0d/%0d want %0d/%0d", sb_cnt, db_cnt, cnt_exp(exp_sb), cnt_exp(exp_db)); end
  endtask

  task automatic test_saturation();
    s_valid_i = 1'b1; s_d = 13'h140E;
    repeat (5) tick();
    s_valid_i = 1'b0;
    tick(); tick();
    checks++; if (16'(s_sb_cnt) !== cnt_exp(3)) begin errors++; $display("FAIL sat_sb got %0d want %0d", s_sb_cnt, cnt_exp(3)); end
    checks++; if (s_db_cnt !== 2'd0) begin errors++; $display("FAIL sat_db got %0d want 0", s_db_cnt); end
    // Clear lands on the same edge the next error word enters the output stage.
    s_valid_i = 1'b1;
    tick();
    s_valid_i = 1'b0; s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    checks++; if (s_sb_err !== 1'b1 || s_q !== 8'hA5) begin errors++; $display("FAIL clr_word got sb=%0b q=%h want 1/a5", s_sb_err, s_q); end
    checks++; if (s_sb_cnt !== 2'd0) begin errors++; $display("FAIL clr_prio got %0d want 0", s_sb_cnt); end
    tick();
    checks++; if (s_sb_cnt !== 2'd0) begin errors++; $display("FAIL clr_once got %0d want 0", s_sb_cnt); end
  endtask

  task automatic test_reset_inflight();
    valid_i = 1'b1; d = 13'h140E; ready_i = 1'b1;
    tick();
    d = 13'h1466;
    tick();
    valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_sb = 0; exp_db = 0;
    checks++; if (valid_o !== 1'b0 || q !== 8'h00) begin errors++; $display("FAIL rst_fly_data got v=%0b q=%h want 0/00", valid_o, q); end
    checks++; if ({syn, sb_err, db_err} !== 6'd0) begin errors++; $display("FAIL rst_fly_flags got %b want 0", {syn, sb_err, db_err}); end
    checks++; if (sb_cnt !== 16'd0 || db_cnt !== 16'd0) begin errors++; $display("FAIL rst_fly_cnt got %0d/%0d want 0/0", sb_cnt, db_cnt); end
    #2 rst = 1'b0;
    tick(); tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_fly_drop valid got %0b want 0", valid_o); end
    valid_i = 1'b1; d = 13'h1EEE;
    tick();
    valid_i = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_lat1 valid got %0b want 0", valid_o); end
    tick();
    checks++; if (valid_o !== 1'b1 || q !== 8'hFF) begin errors++; $display("FAIL rst_lat2 got v=%0b q=%h want 1/ff", valid_o, q); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_p0_and_double();
    test_out_of_range();
    test_back_to_back();
    test_saturation();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
